// File: rtl/adc_trig_pkg.sv
// Shared types and helpers for the adc_trigger capture stage: FSM state encoding,
// slope selector constants and a ceil(log2) helper for sizing pointers and counters.
package adc_trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_DRAIN,
        ST_POST
    } state_e;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_trig_ring.sv
// Pre-trigger sample ring: simple dual-port RAM with synchronous write and a
// registered read port, shaped to map onto block/shadow SRAM.
module adc_trig_ring
    import adc_trig_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset on purpose; a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value while rd_en is low, so it doubles as the
    // output hold stage while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_trigger.sv
// Single-shot level trigger between an AXIS sample source and sink: buffers the last
// PRE_DEPTH samples, then emits a FRAME_LEN frame. ADC_TRIG_EXT_EN adds an external trigger.
module adc_trigger
    import adc_trig_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PRE_DEPTH = 64,
    parameter int FRAME_LEN = 1024
) (
    input  logic              axis_aclk,
    input  logic              axis_areset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic              cfg_slope,
    input  logic              ext_trig,
    output logic              busy,
    output logic              triggered
);

    localparam int AW = clog2(PRE_DEPTH);
    localparam int CW = clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_DEPTH - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [AW:0]   PRE_CNT    = (AW + 1)'(PRE_DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [AW:0]       rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              slope_q, slope_d;
    logic              drain_vld_q, drain_vld_d;

    logic              s_ready;
    logic              m_valid;
    logic              accept;
    logic              emit;
    logic              ring_we;
    logic              ring_re;
    logic [DATA_W-1:0] ring_rdata;
    logic              level_hit;
    logic              ext_hit;
    logic              hit;

    logic              unused_tlast;
    assign unused_tlast = s_axis_tlast;

    adc_trig_ring #(
        .DATA_W (DATA_W),
        .DEPTH  (PRE_DEPTH),
        .ADDR_W (AW)
    ) u_ring (
        .clk     (axis_aclk),
        .rst     (axis_areset),
        .wr_en   (ring_we),
        .wr_addr (wp_q),
        .wr_data (s_axis_tdata),
        .rd_en   (ring_re),
        .rd_addr (rp_q),
        .rd_data (ring_rdata)
    );

    // Handshake and output decode; POST is a combinational pass-through.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            ST_IDLE, ST_FILL, ST_ARMED: s_ready = 1'b1;
            ST_DRAIN:                   m_valid = drain_vld_q;
            ST_POST: begin
                s_ready = m_axis_tready;
                m_valid = s_axis_tvalid;
            end
            default: ;
        endcase
    end

    assign accept        = s_axis_tvalid & s_ready;
    assign emit          = m_valid & m_axis_tready;
    assign s_axis_tready = s_ready & ~axis_areset;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = (state_q == ST_POST) ? s_axis_tdata : ring_rdata;
    assign m_axis_tlast  = (state_q == ST_POST) && (cnt_q == FRAME_LAST);
    assign busy          = (state_q != ST_IDLE);
    assign triggered     = (state_q == ST_DRAIN) || (state_q == ST_POST);

    assign level_hit = (slope_q == SLOPE_RISE)
                     ? ((prev_q < level_q) && (s_axis_tdata >= level_q))
                     : ((prev_q > level_q) && (s_axis_tdata <= level_q));
    assign hit = level_hit | ext_hit;

`ifdef ADC_TRIG_EXT_EN
    logic [2:0] ext_sync_q, ext_sync_d;
    logic       ext_pend_q, ext_pend_d;
    logic       ext_rise;

    // Stages [1:0] synchronise; stage [2] is the delayed copy for edge detection.
    always_comb begin
        ext_sync_d = {ext_sync_q[1:0], ext_trig};
        ext_rise   = ext_sync_q[1] & ~ext_sync_q[2];
        ext_pend_d = (state_q == ST_ARMED) & ((ext_pend_q & ~accept) | ext_rise);
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            ext_sync_q <= '0;
            ext_pend_q <= 1'b0;
        end else begin
            ext_sync_q <= ext_sync_d;
            ext_pend_q <= ext_pend_d;
        end
    end

    assign ext_hit = ext_pend_q;
`else
    logic unused_ext;
    assign unused_ext = ext_trig;
    assign ext_hit    = 1'b0;
`endif

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        rd_cnt_d    = rd_cnt_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        prev_d      = prev_q;
        slope_d     = slope_q;
        drain_vld_d = drain_vld_q;
        ring_we     = 1'b0;
        ring_re     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_arm) begin
                    state_d = ST_FILL;
                    level_d = cfg_level;
                    slope_d = cfg_slope;
                    cnt_d   = '0;
                    wp_d    = '0;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    ring_we = 1'b1;
                    wp_d    = wp_q + AW'(1);
                    prev_d  = s_axis_tdata;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end
                end
                if (cfg_abort) state_d = ST_IDLE;
            end
            ST_ARMED: begin
                if (accept) begin
                    ring_we = 1'b1;
                    wp_d    = wp_q + AW'(1);
                    prev_d  = s_axis_tdata;
                    if (hit) begin
                        // The slot after the hit sample is the oldest entry.
                        state_d  = ST_DRAIN;
                        rp_d     = wp_q + AW'(1);
                        rd_cnt_d = '0;
                        cnt_d    = '0;
                    end
                end
                if (cfg_abort) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                ring_re     = (rd_cnt_q != PRE_CNT) && (!drain_vld_q || m_axis_tready);
                drain_vld_d = ring_re | (drain_vld_q & ~m_axis_tready);
                if (ring_re) begin
                    rp_d     = rp_q + AW'(1);
                    rd_cnt_d = rd_cnt_q + (AW + 1)'(1);
                end
                if (emit) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == PRE_LAST) state_d = ST_POST;
                end
            end
            ST_POST: begin
                if (emit) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == FRAME_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q     <= ST_IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            rd_cnt_q    <= '0;
            cnt_q       <= '0;
            level_q     <= '0;
            prev_q      <= '0;
            slope_q     <= SLOPE_RISE;
            drain_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            rd_cnt_q    <= rd_cnt_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            prev_q      <= prev_d;
            slope_q     <= slope_d;
            drain_vld_q <= drain_vld_d;
        end
    end

endmodule
